// File: rtl/inst_mem_param_if.sv
// Fetch/program-load bus for the parametrised instruction memory.
// master = loader/fetch side, slave = memory.
interface inst_mem_param_if #(
  parameter int DATA_W = 20,
  parameter int ADDR_W = 5
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_err;
  logic              wr_err;
  logic              busy;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data,
    input  rd_data, rd_valid, rd_err, wr_err, busy
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
    output rd_data, rd_valid, rd_err, wr_err, busy
  );
endinterface

// File: rtl/inst_mem_param.sv
// Parametrised instruction memory: registered fetch port, program-load write
// port with write-first forwarding, and a post-reset fill of every entry.
//
//  state  | meaning
//  S_INIT | writing INIT_VALUE to entry ptr each cycle; requests ignored, busy=1
//  S_RUN  | normal fetch/load service until the next reset
module inst_mem_param #(
  parameter int                 DATA_W     = 20,
  parameter int                 ADDR_W     = 5,
  parameter int                 DEPTH      = 32,
  parameter logic [DATA_W-1:0]  INIT_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst,
  inst_mem_param_if.slave   bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_W = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] LAST_W  = DEPTH_W - 1'b1;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_err_q, rd_err_d;
  logic              wr_err_q, wr_err_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              mem_we;
  logic [IDX_W-1:0]  mem_widx;
  logic [DATA_W-1:0] mem_wdata;

  logic              rd_oor, wr_oor, wr_hit;
  logic [IDX_W-1:0]  rd_idx, wr_idx;

  // Full-width compare so DEPTH == 2**ADDR_W never flags a valid address.
  assign rd_oor = {1'b0, bus.rd_addr} >= DEPTH_W;
  assign wr_oor = {1'b0, bus.wr_addr} >= DEPTH_W;
  assign rd_idx = bus.rd_addr[IDX_W-1:0];
  assign wr_idx = bus.wr_addr[IDX_W-1:0];
  assign wr_hit = bus.wr_en && (bus.wr_addr == bus.rd_addr);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    rd_err_d   = 1'b0;
    wr_err_d   = 1'b0;
    mem_we     = 1'b0;
    mem_widx   = ptr_q[IDX_W-1:0];
    mem_wdata  = INIT_VALUE;
    case (state_q)
      S_INIT: begin
        mem_we = 1'b1;
        ptr_d  = ptr_q + 1'b1;
        if (ptr_q == LAST_W) state_d = S_RUN;
      end
      S_RUN: begin
        if (bus.rd_en) begin
          rd_valid_d = 1'b1;
          if (rd_oor) begin
            rd_err_d  = 1'b1;
            rd_data_d = '0;
          end else if (wr_hit) begin
            rd_data_d = bus.wr_data;
          end else begin
            rd_data_d = mem_q[rd_idx];
          end
        end
        if (bus.wr_en) begin
          if (wr_oor) begin
            wr_err_d = 1'b1;
          end else begin
            mem_we    = 1'b1;
            mem_widx  = wr_idx;
            mem_wdata = bus.wr_data;
          end
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_INIT;
      ptr_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
      wr_err_q   <= wr_err_d;
    end
  end

  // Storage is deliberately left alone on the reset edge; the INIT fill follows.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem_q[mem_widx] <= mem_wdata;
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_err   = rd_err_q;
  assign bus.wr_err   = wr_err_q;
  assign bus.busy     = (state_q == S_INIT);

endmodule

// File: tb/tb_inst_mem_param.sv
// Drives three memory configurations with a shared stimulus and checks each
// against a per-instance reference model every cycle.
module tb_inst_mem_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rd_en, wr_en;
  logic [4:0]  rd_addr, wr_addr;
  logic [19:0] wr_data;

  inst_mem_param_if #(.DATA_W(20), .ADDR_W(5)) if_a ();
  inst_mem_param_if #(.DATA_W(20), .ADDR_W(5)) if_b ();
  inst_mem_param_if #(.DATA_W(20), .ADDR_W(1)) if_c ();

  inst_mem_param #(.DATA_W(20), .ADDR_W(5), .DEPTH(32), .INIT_VALUE(20'h00000))
    u_a (.clk(clk), .rst(rst), .bus(if_a));
  inst_mem_param #(.DATA_W(20), .ADDR_W(5), .DEPTH(20), .INIT_VALUE(20'h00000))
    u_b (.clk(clk), .rst(rst), .bus(if_b));
  inst_mem_param #(.DATA_W(20), .ADDR_W(1), .DEPTH(1), .INIT_VALUE(20'hC0000))
    u_c (.clk(clk), .rst(rst), .bus(if_c));

  assign if_a.rd_en = rd_en;   assign if_b.rd_en = rd_en;   assign if_c.rd_en = rd_en;
  assign if_a.wr_en = wr_en;   assign if_b.wr_en = wr_en;   assign if_c.wr_en = wr_en;
  assign if_a.wr_data = wr_data; assign if_b.wr_data = wr_data; assign if_c.wr_data = wr_data;
  assign if_a.rd_addr = rd_addr; assign if_b.rd_addr = rd_addr; assign if_c.rd_addr = rd_addr[0];
  assign if_a.wr_addr = wr_addr; assign if_b.wr_addr = wr_addr; assign if_c.wr_addr = wr_addr[0];

  logic [19:0] o_data [3];
  logic        o_rv [3], o_re [3], o_we [3], o_busy [3];
  assign o_data[0] = if_a.rd_data; assign o_rv[0] = if_a.rd_valid; assign o_re[0] = if_a.rd_err;
  assign o_we[0] = if_a.wr_err;    assign o_busy[0] = if_a.busy;
  assign o_data[1] = if_b.rd_data; assign o_rv[1] = if_b.rd_valid; assign o_re[1] = if_b.rd_err;
  assign o_we[1] = if_b.wr_err;    assign o_busy[1] = if_b.busy;
  assign o_data[2] = if_c.rd_data; assign o_rv[2] = if_c.rd_valid; assign o_re[2] = if_c.rd_err;
  assign o_we[2] = if_c.wr_err;    assign o_busy[2] = if_c.busy;

  int tests = 0;
  int fails = 0;

  int          depth [3] = '{32, 20, 1};
  int          amask [3] = '{31, 31, 1};
  logic [19:0] initv [3] = '{20'h00000, 20'h00000, 20'hC0000};
  logic [19:0] mem [3][32];
  int          init_left [3];
  logic [19:0] e_data [3];
  logic        e_rv [3], e_re [3], e_we [3];

  task automatic chk(input string tag, input int d, input logic [19:0] obs, input logic [19:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, d, obs, exp);
    end
  endtask

  task automatic model(input int d, input logic r, input logic re, input int ra,
                       input logic we, input int wa, input logic [19:0] wd);
    int a_r, a_w;
    a_r = ra & amask[d];
    a_w = wa & amask[d];
    if (r) begin
      init_left[d] = depth[d];
      e_data[d] = '0; e_rv[d] = 1'b0; e_re[d] = 1'b0; e_we[d] = 1'b0;
    end else if (init_left[d] > 0) begin
      init_left[d]--;
      if (init_left[d] == 0)
        for (int i = 0; i < depth[d]; i++) mem[d][i] = initv[d];
      e_rv[d] = 1'b0; e_re[d] = 1'b0; e_we[d] = 1'b0;
    end else begin
      if (re) begin
        e_rv[d] = 1'b1;
        if (a_r >= depth[d]) begin
          e_re[d] = 1'b1; e_data[d] = '0;
        end else begin
          e_re[d] = 1'b0;
          e_data[d] = (we && a_w == a_r) ? wd : mem[d][a_r];
        end
      end else begin
        e_rv[d] = 1'b0; e_re[d] = 1'b0;
      end
      if (we && a_w < depth[d]) mem[d][a_w] = wd;
      e_we[d] = we && (a_w >= depth[d]);
    end
  endtask

  task automatic cyc(input logic r, input logic re, input int ra,
                     input logic we, input int wa, input logic [19:0] wd);
    rst = r; rd_en = re; rd_addr = ra[4:0]; wr_en = we; wr_addr = wa[4:0]; wr_data = wd;
    @(posedge clk);
    for (int d = 0; d < 3; d++) model(d, r, re, ra, we, wa, wd);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("busy",     d, {19'd0, o_busy[d]}, {19'd0, init_left[d] > 0});
      chk("rd_valid", d, {19'd0, o_rv[d]},   {19'd0, e_rv[d]});
      chk("rd_err",   d, {19'd0, o_re[d]},   {19'd0, e_re[d]});
      chk("wr_err",   d, {19'd0, o_we[d]},   {19'd0, e_we[d]});
      chk("rd_data",  d, o_data[d],          e_data[d]);
    end
  endtask

  task automatic rnd_cyc(input logic r);
    cyc(r, 1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
        1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), 20'($urandom));
  endtask

  task automatic rd(input int a);
    cyc(1'b0, 1'b1, a, 1'b0, 0, 20'h0);
  endtask

  task automatic wr(input int a, input logic [19:0] v);
    cyc(1'b0, 1'b0, 0, 1'b1, a, v);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 0, 1'b0, 0, 20'h0);
  endtask

  initial begin
    // Reset, then requests thrown at the memories while they fill.
    cyc(1'b1, 1'b0, 0, 1'b0, 0, 20'h0);
    repeat (32) rnd_cyc(1'b0);
    idle();
    for (int a = 0; a < 32; a++) rd(a);
    idle();

    // Loads, then back-to-back fetches.
    wr(0, 20'h00042);
    wr(7, 20'hC0000);
    rd(0); rd(7); rd(1);
    idle();

    // Same-cycle load and fetch to one address.
    cyc(1'b0, 1'b1, 5, 1'b1, 5, 20'h4A2CB);
    rd(5);
    // Same cycle, different addresses.
    cyc(1'b0, 1'b1, 7, 1'b1, 9, 20'h12345);
    rd(9);

    // Out-of-range handling (meaningful for the 20- and 1-entry instances).
    rd(25);
    wr(25, 20'hFFFFF);
    idle();
    rd(25);
    for (int a = 0; a < 32; a++) rd(a);

    // Reset in the middle of a fill restarts it from scratch.
    wr(3, 20'h3FFFF);
    rd(3);
    cyc(1'b1, 1'b0, 0, 1'b0, 0, 20'h0);
    repeat (9) rnd_cyc(1'b0);
    cyc(1'b1, 1'b1, 3, 1'b1, 3, 20'h11111);
    repeat (34) rnd_cyc(1'b0);
    rd(3); rd(0); rd(1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) rnd_cyc($urandom_range(0, 149) == 0);
    repeat (36) idle();
    for (int a = 0; a < 32; a++) rd(a);
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
